// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free reprogramming.
// Optional clk_pulse output when CLK_DIV_PULSE_OUT_EN is defined.
module clk_div_multi #(
  parameter int CH           = 4,
  parameter int DIV_W        = 8,
  parameter int DEFAULT_HALF = 2,
  localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CH-1:0]    ch_en,
  input  logic             cfg_valid,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [DIV_W-1:0] cfg_half,
  output logic             cfg_ready,
  input  logic             sync_req,
`ifdef CLK_DIV_PULSE_OUT_EN
  output logic [CH-1:0]    clk_pulse,
`endif
  output logic [CH-1:0]    clk_out,
  output logic [CH-1:0]    pending
);

  localparam logic [DIV_W-1:0] RST_HALF = DIV_W'(DEFAULT_HALF);

  // A write is only accepted into a channel whose stage slot is free.
  always_comb begin
    cfg_ready = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (cfg_ch == CW'(k)) begin
        cfg_ready = ~pending[k];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] stage;
    logic [DIV_W-1:0] eff;
    logic [DIV_W-1:0] last;
    logic             out;
    logic             pend;
    logic             run;
    logic             wrap;
    logic             acc;
    logic             apply;
    logic             do_off;
    logic             do_zero;
    logic             do_wrap;
    logic             do_inc;

    // half of 0 behaves as 1 so the channel still divides by 2
    assign eff  = (half == '0) ? DIV_W'(1) : half;
    assign last = eff - DIV_W'(1);
    assign wrap = (cnt >= last);

    // run remembers last edge's enable, so the first enabled edge
    // starts a fresh phase just like a sync does
    assign do_off  = ~ch_en[g];
    assign do_zero = ch_en[g] & (sync_req | ~run);
    assign do_wrap = ch_en[g] & run & ~sync_req & wrap;
    assign do_inc  = ch_en[g] & run & ~sync_req & ~wrap;

    assign acc   = cfg_valid & cfg_ready & (cfg_ch == CW'(g));
    // new half only lands at the end of a full period
    assign apply = pend & (do_off | sync_req | (do_wrap & out));

    // Half-period counter and divided output
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt <= '0;
        out <= 1'b0;
        run <= 1'b0;
      end else begin
        run <= ch_en[g];
        unique case (1'b1)
          do_off, do_zero: begin
            cnt <= '0;
            out <= 1'b0;
          end
          do_wrap: begin
            cnt <= '0;
            out <= ~out;
          end
          do_inc: begin
            cnt <= cnt + DIV_W'(1);
          end
          default: begin
            cnt <= cnt;
          end
        endcase
      end
    end

    // Staged half-period and its hand-over into the live divider
    always_ff @(posedge clock) begin
      if (reset) begin
        half  <= RST_HALF;
        stage <= RST_HALF;
        pend  <= 1'b0;
      end else begin
        if (apply) begin
          half <= stage;
          pend <= 1'b0;
        end
        if (acc) begin
          stage <= cfg_half;
          pend  <= 1'b1;
        end
      end
    end

`ifdef CLK_DIV_PULSE_OUT_EN
    logic pulse;

    // One-clock strobe on the same edge that raises out
    always_ff @(posedge clock) begin
      if (reset) begin
        pulse <= 1'b0;
      end else begin
        pulse <= do_wrap & ~out;
      end
    end

    assign clk_pulse[g] = pulse;
`endif

    assign clk_out[g] = out;
    assign pending[g] = pend;
  end

endmodule
